// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the burst memory responder.
// The enum names the four phases a line transfer goes through.
package burst_mem_pkg;

   localparam int BEATS      = 4;
   localparam int BEAT_W     = 64;
   localparam int LINE_BYTES = 32;
   localparam int OFFSET_W   = $clog2(LINE_BYTES);
   localparam int BEAT_IDX_W = $clog2(BEATS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_BURST,
      ST_DONE
   } state_t;

endpackage

// File: rtl/burst_mem_responder_if.sv
// Physical-memory burst bus as driven by the mp4 cache hierarchy.
// The master is the initiator; the slave is burst_mem_responder.
interface burst_mem_responder_if;
   import burst_mem_pkg::*;

   logic              pmem_read;
   logic              pmem_write;
   logic [31:0]       pmem_address;
   logic [BEAT_W-1:0] pmem_wdata;
   logic              pmem_resp;
   logic [BEAT_W-1:0] pmem_rdata;
   logic              pmem_err;

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_resp, pmem_rdata, pmem_err
   );

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_resp, pmem_rdata, pmem_err
   );

endinterface

// File: rtl/burst_mem_array.sv
// Line storage: DEPTH_LINES lines of BEATS words, one write port and one
// asynchronous read port. Contents are never reset.
module burst_mem_array
   import burst_mem_pkg::*;
#(
   parameter int DEPTH_LINES = 256,
   parameter int IDX_W       = $clog2(DEPTH_LINES)
)
(
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_W-1:0]      wr_index,
   input  logic [BEAT_IDX_W-1:0] wr_beat,
   input  logic [BEAT_W-1:0]     wr_data,
   input  logic [IDX_W-1:0]      rd_index,
   input  logic [BEAT_IDX_W-1:0] rd_beat,
   output logic [BEAT_W-1:0]     rd_data
);

   logic [BEAT_W-1:0] mem [DEPTH_LINES*BEATS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[{wr_index, wr_beat}] <= wr_data;
      end
   end

   assign rd_data = mem[{rd_index, rd_beat}];

endmodule

// File: rtl/burst_mem_responder.sv
// On-chip responder for the 4-beat pmem burst bus with programmable first-beat latency.
// Define BURST_MEM_ERR_CHECK_EN to build the sticky protocol checker driving pmem_err.
module burst_mem_responder
   import burst_mem_pkg::*;
#(
   parameter int DEPTH_LINES = 256,
   parameter int LATENCY     = 8
)
(
   input logic                  clk,
   input logic                  rst,
   burst_mem_responder_if.slave bus
);

   localparam int                 IDX_W    = $clog2(DEPTH_LINES);
   localparam int                 CNT_W    = $clog2(LATENCY + 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   LAT_M1   = CNT_W'(LATENCY - 1);
   localparam logic [BEAT_IDX_W-1:0] BEAT_ONE  = BEAT_IDX_W'(1);
   localparam logic [BEAT_IDX_W-1:0] BEAT_LAST = BEAT_IDX_W'(BEATS - 1);

   state_t                  state;
   logic [CNT_W-1:0]        count;
   logic [IDX_W-1:0]        index;
   logic                    op_write;
   logic [BEAT_IDX_W-1:0]   beat;
   logic                    resp;
   logic [BEAT_W-1:0]       rdata;

   logic                    request;
   logic [IDX_W-1:0]        addr_index;
   logic [IDX_W-1:0]        rd_index;
   logic [BEAT_IDX_W-1:0]   rd_beat;
   logic [BEAT_W-1:0]       rd_word;
   logic                    we;
   logic                    unused_addr_bits;

   assign request          = bus.pmem_read | bus.pmem_write;
   assign addr_index       = bus.pmem_address[OFFSET_W+IDX_W-1:OFFSET_W];
   assign unused_addr_bits = ^{bus.pmem_address[31:OFFSET_W+IDX_W], bus.pmem_address[OFFSET_W-1:0]};

   // Look one beat ahead so the registered rdata lines up with resp.
   always_comb begin
      rd_index = index;
      rd_beat  = '0;
      case (state)
         ST_IDLE:  rd_index = addr_index;
         ST_BURST: rd_beat  = beat + BEAT_ONE;
         default:  ;
      endcase
   end

   assign we = (state == ST_BURST) && op_write && request && !rst;

   burst_mem_array #(.DEPTH_LINES(DEPTH_LINES), .IDX_W(IDX_W)) u_array (
      .clk      (clk),
      .we       (we),
      .wr_index (index),
      .wr_beat  (beat),
      .wr_data  (bus.pmem_wdata),
      .rd_index (rd_index),
      .rd_beat  (rd_beat),
      .rd_data  (rd_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         index    <= '0;
         op_write <= 1'b0;
         beat     <= '0;
         resp     <= 1'b0;
         rdata    <= '0;
      end else begin
         resp  <= 1'b0;
         rdata <= '0;
         case (state)
            ST_IDLE: begin
               if (request) begin
                  index    <= addr_index;
                  op_write <= bus.pmem_write;
                  beat     <= '0;
                  count    <= LAT_M1;
                  // A one-cycle latency skips WAIT entirely.
                  if (LAT_M1 == '0) begin
                     state <= ST_BURST;
                     resp  <= 1'b1;
                     rdata <= bus.pmem_write ? '0 : rd_word;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!request) begin
                  state <= ST_IDLE;
                  count <= '0;
               end else begin
                  count <= count - CNT_ONE;
                  if (count == CNT_ONE) begin
                     state <= ST_BURST;
                     resp  <= 1'b1;
                     rdata <= op_write ? '0 : rd_word;
                  end
               end
            end
            ST_BURST: begin
               if (!request) begin
                  state <= ST_IDLE;
               end else if (beat == BEAT_LAST) begin
                  state <= ST_DONE;
               end else begin
                  beat  <= beat + BEAT_ONE;
                  resp  <= 1'b1;
                  rdata <= op_write ? '0 : rd_word;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.pmem_resp  = resp;
   assign bus.pmem_rdata = rdata;

`ifdef BURST_MEM_ERR_CHECK_EN
   logic                   err;
   logic [31-OFFSET_W:0]   line_addr;

   // Sticky: any violation latches until the next reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err       <= 1'b0;
         line_addr <= '0;
      end else begin
         if (state == ST_IDLE && request) begin
            line_addr <= bus.pmem_address[31:OFFSET_W];
         end
         if (bus.pmem_read && bus.pmem_write) begin
            err <= 1'b1;
         end
         if (state == ST_WAIT || state == ST_BURST) begin
            if (!request) begin
               if (state == ST_WAIT || beat != BEAT_LAST) begin
                  err <= 1'b1;
               end
            end else if (bus.pmem_address[31:OFFSET_W] != line_addr || bus.pmem_write != op_write) begin
               err <= 1'b1;
            end
         end
      end
   end

   assign bus.pmem_err = err;
`else
   assign bus.pmem_err = 1'b0;
`endif

endmodule
